// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard control bus: hazard sources in, stage enables/flushes and debug counters out.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             ifid_use_rs1;
  logic             ifid_use_rs2;
  logic [4:0]       idex_rd;
  logic             idex_memread;
  logic             exmem_branch_taken;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             hazard_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    output idex_rd, idex_memread, exmem_branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
    input  exmem_write, exmem_flush, hazard_err,
    input  stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    input  idex_rd, idex_memread, exmem_branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
    output exmem_write, exmem_flush, hazard_err,
    output stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes, memory-busy freeze with
// timeout watchdog, and saturating debug event counters.
module hazard_control_unit #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  state_e             state_q, state_d, cur_state;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               hazard_err_q, hazard_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   freeze_cnt_q, freeze_cnt_d;
  logic               load_use, run_eval;
  logic               pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic               exmem_write, exmem_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
               ((bus.ifid_use_rs1 && (bus.ifid_rs1 == bus.idex_rd)) ||
                (bus.ifid_use_rs2 && (bus.ifid_rs2 == bus.idex_rd)));
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hazard_err_d = hazard_err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    run_eval     = 1'b0;
    // Outputs during reset follow RUN so they are defined before state_q is first loaded.
    cur_state    = reset ? state_q : RUN;

    case (cur_state)
      RUN: begin
        if (bus.dmem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = '0;
          state_d      = MEM_WAIT;
          wait_cnt_d   = WAIT_W'(1);
          freeze_cnt_d = sat_inc(freeze_cnt_q);
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = '0;
          freeze_cnt_d = sat_inc(freeze_cnt_q);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d      = ERROR;
            hazard_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          run_eval   = 1'b1;
        end
      end
      ERROR: begin
        {pc_write, ifid_write, idex_write, exmem_write} = '0;
        hazard_err_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // A branch flushes the ID instruction, so a simultaneous load-use is moot.
    if (run_eval) begin
      if (bus.exmem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      hazard_err_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      hazard_err_q <= hazard_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_write  = idex_write;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_write = exmem_write;
  assign bus.exmem_flush = exmem_flush;
  assign bus.hazard_err  = hazard_err_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.freeze_cnt  = freeze_cnt_q;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline control responder that drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
- It detects load-use hazards from ID/EX contents and flushes on taken branches resolved in MEM.
- It freezes the whole pipeline while the data memory is busy, with a timeout watchdog.
- It sits beside the decode stage and keeps saturating event counters for debug.

Parameters:
- MAX_WAIT, 64: maximum consecutive busy cycles tolerated in MEM_WAIT before ERROR.
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ifid_rs1  in  5  rs1 of the instruction in ID.
- ifid_rs2  in  5  rs2 of the instruction in ID.
- ifid_use_rs1  in  1  ID instruction reads rs1.
- ifid_use_rs2  in  1  ID instruction reads rs2.
- idex_rd  in  5  destination register held in ID/EX.
- idex_memread  in  1  ID/EX holds a load.
- exmem_branch_taken  in  1  branch in MEM resolved taken.
- dmem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clears to NOP.
- idex_write  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads all-zero controls (bubble).
- exmem_write  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM clears controls.
- hazard_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  load-use stall count.
- flush_cnt  out  CNT_W  branch flush count.
- freeze_cnt  out  CNT_W  memory freeze cycle count.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. State and counters are registered. Enable and flush outputs are combinational from state and inputs.
- Reset (reset==0 at a clk edge):
  - state=RUN, wait_cnt=0, hazard_err=0, all counters=0.
  - The reset has priority over every other event, including mid-MEM_WAIT and ERROR.
  - While reset is held, the combinational outputs are computed as in RUN.
- Default outputs: all *_write=1, all *_flush=0.
- load_use: idex_memread && idex_rd!=0 && ((ifid_use_rs1 && ifid_rs1==idex_rd) || (ifid_use_rs2 && ifid_rs2==idex_rd)).
- RUN, priority order:
  1. dmem_busy=1 (freeze):
     - pc_write, ifid_write, idex_write, exmem_write = 0; no flushes.
     - Next state MEM_WAIT, wait_cnt=1, freeze_cnt+1.
  2. exmem_branch_taken=1 (flush):
     - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1.
     - flush_cnt+1. Any load_use in the same cycle is ignored, because the ID instruction is being flushed.
  3. load_use (stall):
     - pc_write=0, ifid_write=0, idex_flush=1 (bubble), exmem_write=1.
     - stall_cnt+1. The stall lasts exactly one cycle; it clears naturally next cycle because ID/EX then holds the bubble.
- MEM_WAIT:
  - If dmem_busy=1:
    - Full freeze as in RUN rule 1; freeze_cnt+1.
    - If wait_cnt==MAX_WAIT-1, go to ERROR and set hazard_err=1. Otherwise wait_cnt+1.
    - Branch and load_use inputs are ignored while frozen.
  - If dmem_busy=0:
    - Go to RUN with wait_cnt=0.
    - Outputs this cycle follow RUN rules 2–3 evaluated on the current inputs, so a branch held in MEM during the freeze flushes in the release cycle.
- ERROR:
  - All *_write=0, all *_flush=0, hazard_err=1.
  - Stays in ERROR until reset; counters hold.
- Counters saturate at 2^CNT_W-1 and never wrap.
- idex_rd==0 never causes a stall; x0 is hardwired.

Test Plan:
1. Load-use:
   - Stimulus: idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1, then idex_memread=0 the next cycle.
   - Required: one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all defaults; stall_cnt=1.
2. x0 and unused source:
   - Stimulus (a): idex_rd=0 with matching rs1. Stimulus (b): rs1 matches but ifid_use_rs1=0.
   - Required: no stall in either case; stall_cnt stays 0.
3. Branch and load_use together:
   - Stimulus: exmem_branch_taken=1 and load_use=1 in the same cycle.
   - Required: ifid_flush=idex_flush=exmem_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
4. Freeze with held branch:
   - Stimulus: dmem_busy=1 for 3 cycles with branch_taken=1 throughout, then dmem_busy=0.
   - Required: 3 cycles with all writes=0 and no flush; release cycle has flushes asserted; freeze_cnt=3, flush_cnt=1, state back to RUN.
5. Timeout:
   - Stimulus: MAX_WAIT=4, dmem_busy held high.
   - Required: hazard_err=1 after the 4th busy cycle; all enables stay 0 after dmem_busy drops.
   - Then pulse reset=0 for one cycle: hazard_err=0, counters=0, state RUN.
6. Saturation and mid-freeze reset:
   - Stimulus: CNT_W=2 with 5 load-use events; separately, reset=0 asserted while in MEM_WAIT.
   - Required: stall_cnt stops at 3; on reset, state returns to RUN and wait_cnt=0.
